// File: rtl/util_reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its downstream stages.
// The sequencer takes the slave view; whoever drives rst_req and stage_done takes the master view.
interface util_reset_sequencer_if #(
  parameter int N_STAGES = 4
);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic                rst_req;
  logic [N_STAGES-1:0] stage_done;
  logic [N_STAGES-1:0] stage_rst;
  logic                locked;
  logic                fault;
  logic [IDX_W-1:0]    stage_idx;

  modport master (
    output rst_req, stage_done,
    input  stage_rst, locked, fault, stage_idx
  );

  modport slave (
    input  rst_req, stage_done,
    output stage_rst, locked, fault, stage_idx
  );
endinterface

// File: rtl/util_reset_sequencer.sv
// Ordered release of per-stage resets with per-stage acknowledge, timeout retry and sticky fault.
//   state  | meaning
//   HOLD   | all stages in reset, counting the hold time
//   WAIT   | stage idx released, waiting for its done (timeout -> retry)
//   GAP    | stage idx acknowledged, idle before releasing idx+1
//   LOCKED | every stage released and acknowledged
//   FAULT  | retry budget spent, all stages held until rst_req/resetn
module util_reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CNT    = 16,
  parameter int GAP_CNT     = 8,
  parameter int TIMEOUT_CNT = 1000,
  parameter int MAX_RETRY   = 3
) (
  input logic                   clk,
  input logic                   resetn,
  util_reset_sequencer_if.slave bus
);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_GAP,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  state_t              state, state_nx;
  logic [31:0]         cnt, cnt_nx;
  logic [31:0]         retry, retry_nx;
  logic [IDX_W-1:0]    idx, idx_nx, idx_inc;
  logic [N_STAGES-1:0] rst_q, rst_nx, released;
  logic                locked_q, locked_nx;
  logic                fault_q, fault_nx;
  logic                go_hold;

  // Stages above i stay in reset; stages 0..i are released.
  function automatic logic [N_STAGES-1:0] held_mask(input logic [IDX_W-1:0] i);
    logic [N_STAGES-1:0] m;
    for (int j = 0; j < N_STAGES; j++) m[j] = (j > int'(i));
    return m;
  endfunction

  assign released = ~rst_q;
  assign idx_inc  = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      retry    <= '0;
      idx      <= '0;
      rst_q    <= '1;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      retry    <= retry_nx;
      idx      <= idx_nx;
      rst_q    <= rst_nx;
      locked_q <= locked_nx;
      fault_q  <= fault_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 32'd1;
    retry_nx  = retry;
    idx_nx    = idx;
    rst_nx    = rst_q;
    locked_nx = locked_q;
    fault_nx  = fault_q;
    go_hold   = 1'b0;

    if (bus.rst_req) begin
      go_hold  = 1'b1;
      retry_nx = '0;
      fault_nx = 1'b0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (cnt == 32'(HOLD_CNT - 1)) begin
            state_nx = ST_WAIT;
            cnt_nx   = '0;
            idx_nx   = '0;
            rst_nx   = held_mask('0);
          end
        end
        ST_WAIT: begin
          // done sampled on the timeout cycle still counts as done
          if (bus.stage_done[idx]) begin
            cnt_nx = '0;
            if (idx == IDX_W'(N_STAGES - 1)) begin
              state_nx  = ST_LOCKED;
              locked_nx = 1'b1;
              retry_nx  = '0;
            end else begin
              state_nx = ST_GAP;
            end
          end else if (cnt == 32'(TIMEOUT_CNT - 1)) begin
            retry_nx = retry + 32'd1;
            if (retry_nx == 32'(MAX_RETRY)) begin
              state_nx = ST_FAULT;
              cnt_nx   = '0;
              idx_nx   = '0;
              rst_nx   = '1;
              fault_nx = 1'b1;
            end else begin
              go_hold = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if ((bus.stage_done & released) != released) begin
            go_hold = 1'b1;
          end else if (cnt == 32'(GAP_CNT - 1)) begin
            state_nx = ST_WAIT;
            cnt_nx   = '0;
            idx_nx   = idx_inc;
            rst_nx   = held_mask(idx_inc);
          end
        end
        ST_LOCKED: begin
          cnt_nx   = '0;
          retry_nx = '0;
          if (bus.stage_done != '1) go_hold = 1'b1;
        end
        ST_FAULT: begin
          cnt_nx   = '0;
          rst_nx   = '1;
          fault_nx = 1'b1;
        end
        default: go_hold = 1'b1;
      endcase
    end

    if (go_hold) begin
      state_nx  = ST_HOLD;
      cnt_nx    = '0;
      idx_nx    = '0;
      rst_nx    = '1;
      locked_nx = 1'b0;
    end
  end

  assign bus.stage_rst = rst_q;
  assign bus.locked    = locked_q;
  assign bus.fault     = fault_q;
  assign bus.stage_idx = idx;
endmodule

// File: tb/tb_util_reset_sequencer.sv
// Bench for util_reset_sequencer: power-up vector table, directed corner cases,
// then randomized acknowledge traffic checked every cycle against a deadline-based model.
`timescale 1ns/100ps
module tb_util_reset_sequencer;
  localparam int N       = 4;
  localparam int HOLD    = 16;
  localparam int GAP     = 8;
  localparam int TIMEOUT = 1000;
  localparam int RETRIES = 3;

  localparam int M_HOLD = 0, M_WAIT = 1, M_GAP = 2, M_LOCK = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  util_reset_sequencer_if #(.N_STAGES(N)) bus ();

  util_reset_sequencer #(
    .N_STAGES(N), .HOLD_CNT(HOLD), .GAP_CNT(GAP),
    .TIMEOUT_CNT(TIMEOUT), .MAX_RETRY(RETRIES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Acknowledge generators: a 3-cycle echo of ~stage_rst, or random per-stage acks with noise.
  logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;
  logic [N-1:0] ack = '0, noise = '0;
  logic [N-1:0] stuck = '0, force_set = '0, force_drop = '0;
  logic         rnd_en = 1'b0;

  always @(negedge clk) begin
    d1 <= ~bus.stage_rst;
    d2 <= d1;
    d3 <= d2;
    noise <= N'($urandom);
    for (int j = 0; j < N; j++) begin
      if (bus.stage_rst[j])                             ack[j] <= 1'b0;
      else if (ack[j] && $urandom_range(0, 299) == 0)   ack[j] <= 1'b0;
      else if (!ack[j] && $urandom_range(0, 2) == 0)    ack[j] <= 1'b1;
    end
  end

  assign bus.stage_done = ((((rnd_en ? (ack | (bus.stage_rst & noise)) : d3)) & ~stuck)
                           | force_set) & ~force_drop;

  // Reference model: mode, number of released stages, and the edge at which the mode began.
  typedef struct {
    int mode;
    int rel;
    int tries;
    int start;
  } mst_t;

  mst_t m;
  int   edge_no = 0;
  logic chk_en = 1'b0;

  function automatic logic [N-1:0] rel_mask(input int r);
    return (r >= N) ? '1 : N'((1 << r) - 1);
  endfunction

  function automatic mst_t model_next(input mst_t s, input int now, input logic rq,
                                      input logic [N-1:0] dn);
    mst_t r = s;
    int t = now - s.start;
    logic [N-1:0] rm = rel_mask(s.rel);
    if (rq) return '{M_HOLD, 0, 0, now};
    case (s.mode)
      M_HOLD: if (t == HOLD) begin r.mode = M_WAIT; r.rel = 1; r.start = now; end
      M_WAIT: begin
        if (dn[s.rel-1]) begin
          r.start = now;
          if (s.rel == N) begin r.mode = M_LOCK; r.tries = 0; end
          else r.mode = M_GAP;
        end else if (t == TIMEOUT) begin
          r.tries = s.tries + 1;
          r.start = now;
          r.rel   = 0;
          r.mode  = (r.tries == RETRIES) ? M_FAULT : M_HOLD;
        end
      end
      M_GAP: begin
        if ((dn & rm) != rm) begin r.mode = M_HOLD; r.rel = 0; r.start = now; end
        else if (t == GAP) begin r.mode = M_WAIT; r.rel = s.rel + 1; r.start = now; end
      end
      M_LOCK: if (dn != '1) begin r.mode = M_HOLD; r.rel = 0; r.start = now; end
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m <= '{M_HOLD, 0, 0, edge_no};
    end else begin
      m       <= model_next(m, edge_no + 1, bus.rst_req, bus.stage_done);
      edge_no <= edge_no + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("model", {24'd0, bus.stage_rst, bus.locked, bus.fault, bus.stage_idx},
          {24'd0, ~rel_mask(m.rel), m.mode == M_LOCK, m.mode == M_FAULT,
           2'((m.rel == 0) ? 0 : m.rel - 1)});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [N-1:0] rst, input logic lk,
                         input logic flt, input logic [1:0] idx);
    chk(name, {26'd0, bus.stage_rst, bus.locked, bus.fault}, {26'd0, rst, lk, flt});
    chk({name, "_idx"}, {30'd0, bus.stage_idx}, {30'd0, idx});
  endtask

  task automatic wait_locked(input string name);
    int k = 0;
    while (!bus.locked && k < 300) begin step(1); k++; end
    chk(name, {31'd0, bus.locked}, 32'd1);
  endtask

  task automatic pulse_req();
    bus.rst_req = 1'b1;
    step(1);
    bus.rst_req = 1'b0;
  endtask

  typedef struct {
    int           adv;
    logic [N-1:0] rst;
    logic         lk;
    logic [1:0]   idx;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k;
    // edges counted from resetn deassertion; echo acks arrive 3 edges after release
    tbl[0] = '{15, 4'b1111, 1'b0, 2'd0};
    tbl[1] = '{1,  4'b1110, 1'b0, 2'd0};
    tbl[2] = '{10, 4'b1110, 1'b0, 2'd0};
    tbl[3] = '{1,  4'b1100, 1'b0, 2'd1};
    tbl[4] = '{11, 4'b1000, 1'b0, 2'd2};
    tbl[5] = '{11, 4'b0000, 1'b0, 2'd3};
    tbl[6] = '{2,  4'b0000, 1'b0, 2'd3};
    tbl[7] = '{1,  4'b0000, 1'b1, 2'd3};

    resetn      = 1'b0;
    bus.rst_req = 1'b0;
    step(1);
    chk_out("reset", 4'b1111, 1'b0, 1'b0, 2'd0);
    chk_en = 1'b1;
    step(4);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].adv);
      chk_out($sformatf("powerup_%0d", i), tbl[i].rst, tbl[i].lk, 1'b0, tbl[i].idx);
    end

    // Stage 1 never acknowledges: three timeouts, then fault.
    stuck = 4'b0010;
    pulse_req();
    step(1026);
    chk_out("wait_s1", 4'b1100, 1'b0, 1'b0, 2'd1);
    step(1);
    chk_out("timeout1", 4'b1111, 1'b0, 1'b0, 2'd0);
    k = 1027;
    while (!bus.fault && k < 4000) begin step(1); k++; end
    chk("fault_edge", 32'(k), 32'd3081);
    step(10000);
    chk_out("fault_sticky", 4'b1111, 1'b0, 1'b1, 2'd0);
    stuck = '0;
    pulse_req();
    chk_out("fault_clear", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(15);
    chk_out("refault_hold", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1);
    chk_out("refault_rel0", 4'b1110, 1'b0, 1'b0, 2'd0);
    wait_locked("relock_after_fault");

    // One-cycle loss of done while locked.
    force_drop = 4'b0100;
    step(1);
    force_drop = '0;
    chk_out("drop_locked", 4'b1111, 1'b0, 1'b0, 2'd0);
    wait_locked("relock_after_drop");

    // rst_req held 20 cycles during the gap after stage 1.
    pulse_req();
    step(32);
    chk_out("gap_s1", 4'b1100, 1'b0, 1'b0, 2'd1);
    bus.rst_req = 1'b1;
    step(1);
    chk_out("req_in_gap", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(19);
    bus.rst_req = 1'b0;
    step(15);
    chk_out("req_hold", 4'b1111, 1'b0, 1'b0, 2'd0);
    step(1);
    chk_out("req_rel0", 4'b1110, 1'b0, 1'b0, 2'd0);
    wait_locked("relock_after_req");

    // Done arriving on the timeout cycle wins.
    stuck = 4'b0010;
    pulse_req();
    step(1026);
    force_set = 4'b0010;
    step(1);
    chk_out("done_on_timeout", 4'b1100, 1'b0, 1'b0, 2'd1);
    stuck     = '0;
    force_set = '0;
    step(8);
    chk_out("after_late_done", 4'b1000, 1'b0, 1'b0, 2'd2);

    // rst_req together with the last stage's done.
    stuck = 4'b1000;
    k = 0;
    while (bus.stage_rst != '0 && k < 50) begin step(1); k++; end
    chk("reach_s3", {28'd0, bus.stage_rst}, 32'd0);
    step(2);
    bus.rst_req = 1'b1;
    force_set   = 4'b1000;
    step(1);
    chk_out("req_vs_done", 4'b1111, 1'b0, 1'b0, 2'd0);
    bus.rst_req = 1'b0;
    force_set   = '0;
    stuck       = '0;
    wait_locked("relock_after_race");

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst", {28'd0, bus.stage_rst}, 32'hF);
    chk("async_locked", {31'd0, bus.locked}, 32'd0);
    resetn = 1'b1;
    wait_locked("relock_after_async");

    // Randomized acknowledge traffic with occasional stuck stages and restarts.
    rnd_en = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (i % 4000 == 0)
        stuck = ($urandom_range(0, 2) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      bus.rst_req = ($urandom_range(0, 699) == 0);
      step(1);
    end
    bus.rst_req = 1'b0;
    step(1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/util_reset_sequencer.md
Name: util_reset_sequencer

Overview:
- Consumes the reset pulse from the clock/lock reset controller and produces an ordered set of per-stage resets for downstream domains.
- Holds all stages in reset, then releases them one at a time. Each stage must acknowledge with a done signal before the next stage is released.
- Reports a combined `locked` status back to the system once every stage has acknowledged.
- Stages that never acknowledge are retried, up to a fixed number of attempts, after which the block latches a fault.

Parameters:
- N_STAGES, 4: number of sequenced reset outputs (1..16).
- HOLD_CNT, 16: cycles all stages are held in reset before stage 0 is released (>=1).
- GAP_CNT, 8: idle cycles between a stage's done and the next stage's release (>=1).
- TIMEOUT_CNT, 1000: cycles to wait for stage_done[i] after releasing stage i (>=2).
- MAX_RETRY, 3: number of timeouts tolerated before FAULT (>=1).

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- resetn, input, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is sampled by clk.
- rst_req, input, 1: synchronous active-high restart request, e.g. from the upstream reset controller.
- stage_done, input, N_STAGES: per-stage "out of reset and ready" acknowledge; level, synchronous to clk.
- stage_rst, output, N_STAGES: per-stage active-high reset; registered.
- locked, output, 1: all stages released and acknowledged; registered.
- fault, output, 1: retry budget exhausted; sticky until rst_req or resetn; registered.
- stage_idx, output, clog2(N_STAGES) (min 1): index of the stage currently being released or waited on; registered.

Behaviour:
- resetn=0 (async):
  - stage_rst = all 1, locked = 0, fault = 0, stage_idx = 0.
  - State = HOLD, counter = 0, retry = 0.
  - After resetn deasserts, the sequence starts without needing rst_req.
- States: HOLD, WAIT, GAP, LOCKED, FAULT. Single 32-bit counter, cleared on every state entry.
- HOLD:
  - stage_rst = all 1, locked = 0.
  - The counter increments each cycle. When counter == HOLD_CNT-1: go to WAIT with stage_idx = 0 and stage_rst[0] cleared on the same edge.
  - Stage 0 therefore falls exactly HOLD_CNT cycles after HOLD entry.
- WAIT (stage i):
  - stage_rst[j] = 0 for j <= i, 1 for j > i.
  - If stage_done[i] = 1:
    - i == N_STAGES-1: go to LOCKED; locked = 1 on that edge.
    - otherwise: go to GAP.
  - Else if counter == TIMEOUT_CNT-1: retry = retry+1.
    - New retry == MAX_RETRY: go to FAULT.
    - Otherwise: go to HOLD (all stage_rst reasserted on that edge).
  - stage_done sampled 1 on the timeout cycle counts as done; done wins over timeout.
- GAP:
  - The counter runs to GAP_CNT-1, then stage_idx = i+1 and stage_rst[i+1] is cleared; go to WAIT.
  - If any stage_done[j] with j <= i drops during GAP, go to HOLD; retry is unchanged.
- LOCKED:
  - locked = 1, retry cleared to 0.
  - If any stage_done bit drops: go to HOLD, locked = 0 on that edge.
- FAULT:
  - stage_rst = all 1, fault = 1, locked = 0.
  - Only rst_req or resetn exits FAULT.
- rst_req = 1, in any state:
  - Highest priority: next state is HOLD, counter = 0, retry = 0, fault = 0, locked = 0, stage_rst = all 1, stage_idx = 0 on that edge.
  - rst_req held high keeps the block in HOLD with the counter at 0. Release begins HOLD_CNT cycles after rst_req falls.
- stage_done bits for stages not yet released are ignored.
- No combinational paths from inputs to outputs.

Test Plan:
1. Power-up: resetn low 5 cycles then high, stage_done echoes ~stage_rst after 3 cycles (defaults) -> stage_rst[0] falls 16 cycles after the deassert edge; each later stage falls 8 cycles after the previous done; locked rises on the edge sampling stage_done[3]=1; stage_rst = 4'b0000.
2. Timeout/retry: stage_done[1] stuck 0 -> after 1000 cycles in WAIT for stage 1, all stage_rst go to 1 and HOLD restarts; after the 3rd timeout, fault = 1, stage_rst = 4'b1111, locked = 0; fault persists 10000 cycles; a 1-cycle rst_req clears fault and stage 0 releases 16 cycles later.
3. Loss of done while LOCKED: drop stage_done[2] for 1 cycle -> locked = 0 and stage_rst = 4'b1111 on the next edge; full resequence completes; retry counter not incremented.
4. rst_req mid-sequence: assert rst_req during GAP after stage 1 -> stage_rst = 4'b1111, stage_idx = 0 on the next edge; hold rst_req 20 cycles -> stage 0 releases exactly 16 cycles after rst_req falls.
5. Simultaneous events: stage_done[i] rises on the timeout cycle -> treated as done, no retry. rst_req and stage_done[3] in the same cycle -> HOLD wins, locked stays 0.
6. Async reset mid-operation: resetn pulses low for 1 ns between edges while LOCKED -> stage_rst = all 1 and locked = 0 immediately (no clock edge needed); sequence restarts after deassert.
